// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: counts rising spike edges over a 2^WINDOW_LOG2-cycle
// window to give a firing rate, and measures the inter-spike interval (ISI)
// between consecutive edges. Both results are registered and announced with
// one-cycle valid pulses.
module spike_rate_decoder #(
    parameter int WINDOW_LOG2 = 8,
    parameter int SYNC_STAGES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       spike_in,
    output logic [7:0] rate,
    output logic       rate_valid,
    output logic       rate_sat,
    output logic [7:0] isi,
    output logic       isi_valid
);

    // Saturating edge accumulator; 256 is the "more than 255" marker.
    function automatic logic [8:0] sat_inc9(input logic [8:0] v, input logic inc);
        logic [8:0] r;
        if (inc && (v != 9'd256)) begin
            r = v + 9'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Saturating 8-bit interval counter increment.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    logic                   s_s;
    logic                   s_q_r;
    logic [WINDOW_LOG2-1:0] win_cnt_r;
    logic [8:0]             count_r;
    logic [7:0]             isi_cnt_r;
    logic                   first_seen_r;
    logic [7:0]             rate_r;
    logic                   rate_sat_r;
    logic                   rate_valid_r;
    logic [7:0]             isi_r;
    logic                   isi_valid_r;

    logic                   edge_s;
    logic                   last_s;
    logic [9:0]             total_s;
    logic [7:0]             rate_next_s;
    logic                   sat_next_s;
    logic [8:0]             count_next_s;
    logic [7:0]             isi_cnt_next_s;

    generate
        if (SYNC_STAGES == 2) begin : g_sync
            logic [1:0] sync_r;
            // Two-flop synchroniser for pin-sourced spikes; samples even when ena is low
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_r <= 2'b00;
                end else begin
                    sync_r <= {sync_r[0], spike_in};
                end
            end
            assign s_s = sync_r[1];
        end else begin : g_direct
            assign s_s = spike_in;
        end
    endgenerate

    // Edge detect, window-close totals and next counter values
    always_comb begin
        edge_s  = s_s & ~s_q_r;
        last_s  = &win_cnt_r;
        // An edge in the closing cycle belongs to the window being closed.
        total_s = {1'b0, count_r} + {9'd0, edge_s};
        if (total_s > 10'd255) begin
            rate_next_s = 8'hFF;
            sat_next_s  = 1'b1;
        end else begin
            rate_next_s = total_s[7:0];
            sat_next_s  = 1'b0;
        end
        if (last_s) begin
            count_next_s = 9'd0;
        end else begin
            count_next_s = sat_inc9(count_r, edge_s);
        end
        // The edge cycle itself is cycle 1 of the following interval.
        if (edge_s) begin
            isi_cnt_next_s = 8'd1;
        end else begin
            isi_cnt_next_s = sat_inc8(isi_cnt_r);
        end
    end

    // Window counter, edge count and registered rate outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q_r        <= 1'b0;
            win_cnt_r    <= '0;
            count_r      <= 9'd0;
            rate_r       <= 8'd0;
            rate_sat_r   <= 1'b0;
            rate_valid_r <= 1'b0;
        end else if (ena) begin
            s_q_r     <= s_s;
            win_cnt_r <= win_cnt_r + {{(WINDOW_LOG2-1){1'b0}}, 1'b1};
            count_r   <= count_next_s;
            if (last_s) begin
                rate_r       <= rate_next_s;
                rate_sat_r   <= sat_next_s;
                rate_valid_r <= 1'b1;
            end else begin
                rate_valid_r <= 1'b0;
            end
        end else begin
            rate_valid_r <= 1'b0;
        end
    end

    // Interval counter and registered ISI outputs; the first edge only arms reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi_cnt_r    <= 8'd0;
            first_seen_r <= 1'b0;
            isi_r        <= 8'd0;
            isi_valid_r  <= 1'b0;
        end else if (ena) begin
            isi_cnt_r <= isi_cnt_next_s;
            if (edge_s) begin
                if (first_seen_r) begin
                    isi_r       <= isi_cnt_r;
                    isi_valid_r <= 1'b1;
                end else begin
                    first_seen_r <= 1'b1;
                    isi_valid_r  <= 1'b0;
                end
            end else begin
                isi_valid_r <= 1'b0;
            end
        end else begin
            isi_valid_r <= 1'b0;
        end
    end

    assign rate       = rate_r;
    assign rate_valid = rate_valid_r;
    assign rate_sat   = rate_sat_r;
    assign isi        = isi_r;
    assign isi_valid  = isi_valid_r;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder. Instance A: WINDOW_LOG2=4, no synchroniser.
// Instance B: WINDOW_LOG2=10, two-stage synchroniser. Expected rate/ISI
// results are pushed to queues as stimulus is driven and popped when the
// DUT raises its valid pulses.
module tb_spike_rate_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a_n, ena_a, spike_a;
    logic [7:0] rate_a, isi_a;
    logic       rate_valid_a, rate_sat_a, isi_valid_a;
    logic       rst_b_n, ena_b, spike_b;
    logic [7:0] rate_b, isi_b;
    logic       rate_valid_b, rate_sat_b, isi_valid_b;

    spike_rate_decoder #(.WINDOW_LOG2(4), .SYNC_STAGES(0)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .ena(ena_a), .spike_in(spike_a),
        .rate(rate_a), .rate_valid(rate_valid_a), .rate_sat(rate_sat_a),
        .isi(isi_a), .isi_valid(isi_valid_a)
    );

    spike_rate_decoder #(.WINDOW_LOG2(10), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .ena(ena_b), .spike_in(spike_b),
        .rate(rate_b), .rate_valid(rate_valid_b), .rate_sat(rate_sat_b),
        .isi(isi_b), .isi_valid(isi_valid_b)
    );

    typedef struct {
        int tag;
        int val;
        bit sat;
    } exp_t;

    exp_t q_rate[$];
    exp_t q_isi[$];
    bit   pat_ena[$];
    bit   pat_lvl[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic do_reset(input int which);
        if (which == 0) begin
            rst_a_n = 1'b0; ena_a = 1'b1; spike_a = 1'b0;
        end else begin
            rst_b_n = 1'b0; ena_b = 1'b1; spike_b = 1'b0;
        end
        repeat (2) @(negedge clk);
        if (which == 0) rst_a_n = 1'b1;
        else            rst_b_n = 1'b1;
    endtask

    // Drive the queued pattern (one entry per clock) and scoreboard both valid streams.
    task automatic run_pattern(input int which, input int wlog2, input int sync);
        int   en_idx    = 0;
        int   win_pos   = 0;
        int   win_edges = 0;
        int   last_edge = -1;
        bit   prev = 1'b0;
        bit   h0 = 1'b0;
        bit   h1 = 1'b0;
        bit   s, e;
        int   d;
        exp_t ex;
        logic       rv, rs, iv;
        logic [7:0] rr, ir;
        for (int i = 0; i < pat_lvl.size(); i++) begin
            if (which == 0) begin
                ena_a = pat_ena[i]; spike_a = pat_lvl[i];
            end else begin
                ena_b = pat_ena[i]; spike_b = pat_lvl[i];
            end
            if (sync == 2) s = h1;
            else           s = pat_lvl[i];
            h1 = h0;
            h0 = pat_lvl[i];
            if (pat_ena[i]) begin
                en_idx++;
                e    = s & ~prev;
                prev = s;
                if (e) begin
                    win_edges++;
                    if (last_edge >= 0) begin
                        d = en_idx - last_edge;
                        q_isi.push_back('{tag: i, val: (d > 255) ? 255 : d, sat: 1'b0});
                    end
                    last_edge = en_idx;
                end
                if (win_pos == (1 << wlog2) - 1) begin
                    q_rate.push_back('{tag: i, val: (win_edges > 255) ? 255 : win_edges,
                                       sat: (win_edges > 255)});
                    win_edges = 0;
                    win_pos   = 0;
                end else begin
                    win_pos++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            rv = (which == 0) ? rate_valid_a : rate_valid_b;
            rr = (which == 0) ? rate_a       : rate_b;
            rs = (which == 0) ? rate_sat_a   : rate_sat_b;
            iv = (which == 0) ? isi_valid_a  : isi_valid_b;
            ir = (which == 0) ? isi_a        : isi_b;
            if (rv === 1'b1) begin
                n_vec++;
                if (q_rate.size() == 0) begin
                    n_fail++;
                    $display("FAIL rate_unexpected dut%0d cycle %0d: rate_valid=1 rate=%0d, required no pulse", which, i, rr);
                end else begin
                    ex = q_rate.pop_front();
                    if (ex.tag != i || rr !== ex.val[7:0] || rs !== ex.sat) begin
                        n_fail++;
                        $display("FAIL rate dut%0d cycle %0d: got rate=%0d sat=%0d, required rate=%0d sat=%0d at cycle %0d",
                                 which, i, rr, rs, ex.val, ex.sat, ex.tag);
                    end
                end
            end else if (q_rate.size() > 0 && q_rate[0].tag == i) begin
                n_vec++;
                n_fail++;
                ex = q_rate.pop_front();
                $display("FAIL rate_missing dut%0d cycle %0d: rate_valid=%b, required pulse with rate=%0d", which, i, rv, ex.val);
            end
            if (iv === 1'b1) begin
                n_vec++;
                if (q_isi.size() == 0) begin
                    n_fail++;
                    $display("FAIL isi_unexpected dut%0d cycle %0d: isi_valid=1 isi=%0d, required no pulse", which, i, ir);
                end else begin
                    ex = q_isi.pop_front();
                    if (ex.tag != i || ir !== ex.val[7:0]) begin
                        n_fail++;
                        $display("FAIL isi dut%0d cycle %0d: got isi=%0d, required isi=%0d at cycle %0d",
                                 which, i, ir, ex.val, ex.tag);
                    end
                end
            end else if (q_isi.size() > 0 && q_isi[0].tag == i) begin
                n_vec++;
                n_fail++;
                ex = q_isi.pop_front();
                $display("FAIL isi_missing dut%0d cycle %0d: isi_valid=%b, required pulse with isi=%0d", which, i, iv, ex.val);
            end
        end
        pat_ena.delete();
        pat_lvl.delete();
        n_vec++;
        if (q_rate.size() != 0 || q_isi.size() != 0) begin
            n_fail++;
            $display("FAIL pending dut%0d: %0d rate and %0d isi results never arrived, required 0",
                     which, q_rate.size(), q_isi.size());
        end
        q_rate.delete();
        q_isi.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (rate_a !== 8'd0 || rate_valid_a !== 1'b0 || rate_sat_a !== 1'b0 ||
            isi_a !== 8'd0 || isi_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rate=%0d rv=%b sat=%b isi=%0d iv=%b, required all 0",
                     rate_a, rate_valid_a, rate_sat_a, isi_a, isi_valid_a);
        end
    endtask

    task automatic test_rate();
        do_reset(0);
        for (int i = 0; i < 50; i++) begin
            pat_ena.push_back(1'b1);
            pat_lvl.push_back((i < 48) && (i % 4 == 0));
        end
        run_pattern(0, 4, 0);
        n_vec++;
        if (rate_a !== 8'd4 || rate_sat_a !== 1'b0 || isi_a !== 8'd4) begin
            n_fail++;
            $display("FAIL rate_hold: rate=%0d sat=%b isi=%0d, required 4 0 4", rate_a, rate_sat_a, isi_a);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_a_n = 1'b0;
        #1;
        n_vec++;
        if (rate_a !== 8'd0) begin
            n_fail++; $display("FAIL async_rate: got %0d, required 0", rate_a);
        end
        n_vec++;
        if (isi_a !== 8'd0) begin
            n_fail++; $display("FAIL async_isi: got %0d, required 0", isi_a);
        end
        n_vec++;
        if (rate_valid_a !== 1'b0 || rate_sat_a !== 1'b0 || isi_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_flags: rv=%b sat=%b iv=%b, required 0 0 0", rate_valid_a, rate_sat_a, isi_valid_a);
        end
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        // Single edge right after release: counted in the rate, no ISI report.
        for (int i = 0; i < 20; i++) begin
            pat_ena.push_back(1'b1);
            pat_lvl.push_back(i < 3);
        end
        run_pattern(0, 4, 0);
        n_vec++;
        if (isi_a !== 8'd0 || rate_a !== 8'd1) begin
            n_fail++;
            $display("FAIL post_reset_edge: isi=%0d rate=%0d, required isi=0 rate=1", isi_a, rate_a);
        end
    endtask

    task automatic test_wide_pulse();
        do_reset(0);
        for (int i = 0; i < 50; i++) begin
            pat_ena.push_back(1'b1);
            pat_lvl.push_back(((i >= 2) && (i <= 11)) || (i == 31));
        end
        run_pattern(0, 4, 0);
        n_vec++;
        if (rate_a !== 8'd0 || isi_a !== 8'd29) begin
            n_fail++;
            $display("FAIL wide_boundary: rate=%0d isi=%0d, required rate=0 isi=29", rate_a, isi_a);
        end
    endtask

    task automatic test_isi();
        do_reset(0);
        for (int i = 0; i < 340; i++) begin
            pat_ena.push_back(1'b1);
            pat_lvl.push_back((i == 9) || (i == 16) || (i == 316) || (i == 321));
        end
        run_pattern(0, 4, 0);
        n_vec++;
        if (isi_a !== 8'd5) begin
            n_fail++;
            $display("FAIL isi_final: got %0d, required 5", isi_a);
        end
    endtask

    task automatic test_enable();
        do_reset(0);
        for (int i = 0; i < 44; i++) begin
            if (i >= 8 && i <= 27) begin
                pat_ena.push_back(1'b0);
                pat_lvl.push_back(i % 2 == 1);
            end else begin
                pat_ena.push_back(1'b1);
                pat_lvl.push_back((i == 1) || (i == 5) || (i == 30));
            end
        end
        run_pattern(0, 4, 0);
        n_vec++;
        if (rate_a !== 8'd3 || isi_a !== 8'd5) begin
            n_fail++;
            $display("FAIL enable_hold: rate=%0d isi=%0d, required rate=3 isi=5", rate_a, isi_a);
        end
    endtask

    task automatic test_saturation();
        rst_a_n = 1'b0;
        do_reset(1);
        for (int i = 0; i < 2052; i++) begin
            pat_ena.push_back(1'b1);
            if (i < 1022) pat_lvl.push_back(i % 2 == 0);
            else          pat_lvl.push_back((i == 1100) || (i == 1200) || (i == 1300));
        end
        run_pattern(1, 10, 2);
        n_vec++;
        if (rate_b !== 8'd3 || rate_sat_b !== 1'b0 || isi_b !== 8'd100) begin
            n_fail++;
            $display("FAIL sat_recover: rate=%0d sat=%b isi=%0d, required rate=3 sat=0 isi=100",
                     rate_b, rate_sat_b, isi_b);
        end
    endtask

    initial begin
        rst_a_n = 1'b0; ena_a = 1'b1; spike_a = 1'b0;
        rst_b_n = 1'b0; ena_b = 1'b1; spike_b = 1'b0;
        test_reset();
        test_rate();
        test_async_reset();
        test_wide_pulse();
        test_isi();
        test_enable();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
